// File: rtl/apb_timer_lite.sv
// apb_timer_lite: APB slave timer with 4-bit prescaler, compare match,
// auto-reload or one-shot mode, and a level event output.
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   PADDR, PWDATA, PWRITE, PSEL,
//   PENABLE                          : APB request
//   PRDATA, PREADY, PSLVERR          : APB response (zero wait states)
//   event_o                          : MATCH & IRQ_EN
// Register map: 0x0 CTRL {PRESC[11:8], IRQ_EN[2], AUTO_RELOAD[1], EN[0]},
//               0x4 COUNT, 0x8 CMP, 0xC STATUS {MATCH[0], W1C}.
module apb_timer_lite #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      event_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 auto_q, auto_d;
  logic                 irq_en_q, irq_en_d;
  logic [3:0]           presc_q, presc_d;
  logic [3:0]           psc_q, psc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
  logic                 match_q, match_d;

  logic access;
  logic addr_err;
  logic wr_en;
  logic wr_ctrl, wr_count, wr_cmp, wr_status;
  logic en;
  logic tick;
  logic hit;

  always_comb begin
    access    = PSEL & PENABLE;
    addr_err  = (PADDR[APB_ADDR_WIDTH-1:4] != '0) || (PADDR[1:0] != 2'b00);
    wr_en     = access & PWRITE & ~addr_err;
    wr_ctrl   = wr_en && (PADDR[3:2] == 2'd0);
    wr_count  = wr_en && (PADDR[3:2] == 2'd1);
    wr_cmp    = wr_en && (PADDR[3:2] == 2'd2);
    wr_status = wr_en && (PADDR[3:2] == 2'd3);
    en        = (state_q == RUN);
    tick      = en && (psc_q == presc_q);
    hit       = tick && (count_q == cmp_q);
  end

  // EN is the FSM state itself; a CTRL write overrides a one-shot stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_ctrl && PWDATA[0]) state_d = RUN;
      end
      RUN: begin
        if (hit && !auto_q) state_d = IDLE;
        if (wr_ctrl)        state_d = PWDATA[0] ? RUN : IDLE;
      end
    endcase
  end

  always_comb begin
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    count_d  = count_q;
    match_d  = match_q;
    psc_d    = psc_q;

    if (wr_ctrl) begin
      auto_d   = PWDATA[1];
      irq_en_d = PWDATA[2];
      presc_d  = PWDATA[11:8];
    end
    if (wr_cmp) cmp_d = CNT_WIDTH'(PWDATA);

    if (tick) count_d = (hit && auto_q) ? '0 : count_q + CNT_WIDTH'(1);
    if (wr_count) count_d = CNT_WIDTH'(PWDATA);

    // Set has priority over the W1C clear.
    if (wr_status && PWDATA[0]) match_d = 1'b0;
    if (hit)                    match_d = 1'b1;

    if (en) psc_d = tick ? '0 : psc_q + 4'd1;
    if (wr_count || state_d == IDLE) psc_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= '0;
      psc_q    <= '0;
      count_q  <= '0;
      cmp_q    <= '1;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (access && !addr_err) begin
      case (PADDR[3:2])
        2'd0:    PRDATA = {20'd0, presc_q, 5'd0, irq_en_q, auto_q, en};
        2'd1:    PRDATA = 32'(count_q);
        2'd2:    PRDATA = 32'(cmp_q);
        default: PRDATA = {31'd0, match_q};
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = access & addr_err;
  assign event_o = match_q & irq_en_q;

endmodule

// File: tb/tb_apb_timer_lite.sv
module tb_apb_timer_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, event_o;

  always #5 clk = ~clk;

  apb_timer_lite #(.APB_ADDR_WIDTH(12), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .event_o(event_o)
  );

  // Reference model: architectural register contents.
  bit        m_en, m_auto, m_irq, m_match;
  bit [3:0]  m_presc, m_psc;
  bit [31:0] m_cnt, m_cmp = 32'hFFFF_FFFF;

  typedef struct { logic [31:0] data; logic err; } rd_t;
  rd_t rdq[$];
  bit  evq[$];

  int  errors = 0;
  int  checks = 0;
  bit  started = 0;

  function automatic bit bad(logic [11:0] a);
    return (a[11:4] != 8'd0) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    if (bad(a)) return 32'd0;
    case (a[3:2])
      2'd0:    return {20'd0, m_presc, 5'd0, m_irq, m_auto, m_en};
      2'd1:    return m_cnt;
      2'd2:    return m_cmp;
      default: return {31'd0, m_match};
    endcase
  endfunction

  task automatic model_edge(bit r, bit acc, bit w, logic [11:0] a, logic [31:0] d);
    bit        we, tick, hit;
    bit [31:0] nc;
    if (r) begin
      m_en = 0; m_auto = 0; m_irq = 0; m_match = 0;
      m_presc = 0; m_psc = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
    end else begin
      we   = acc && w && !bad(a);
      tick = m_en && (m_psc == m_presc);
      hit  = tick && (m_cnt == m_cmp);
      nc   = m_cnt;
      if (tick) nc = (hit && m_auto) ? 32'd0 : m_cnt + 32'd1;
      if (m_en) m_psc = tick ? 4'd0 : m_psc + 4'd1;
      if (we && a[3:2] == 2'd3 && d[0]) m_match = 0;
      if (hit) m_match = 1;
      if (hit && !m_auto) m_en = 0;
      if (we && a[3:2] == 2'd0) begin
        m_en = d[0]; m_auto = d[1]; m_irq = d[2]; m_presc = d[11:8];
      end
      if (we && a[3:2] == 2'd2) m_cmp = d;
      if (we && a[3:2] == 2'd1) begin
        nc = d; m_psc = 0;
      end
      if (!m_en) m_psc = 0;
      m_cnt = nc;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, queue expectations, advance the model.
  task automatic step(bit r, bit s, bit e, bit w, logic [11:0] a, logic [31:0] d);
    rd_t x;
    rst = r; PSEL = s; PENABLE = e; PWRITE = w; PADDR = a; PWDATA = d;
    if (started) begin
      evq.push_back(m_match & m_irq);
      if (s && e) begin
        x.data = m_read(a);
        x.err  = bad(a);
        rdq.push_back(x);
      end
    end
    @(posedge clk);
    model_edge(r, s && e, w, a, d);
    #1;
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d);
    step(0, 1, 0, 1, a, d);
    step(0, 1, 1, 1, a, d);
  endtask

  task automatic rd(logic [11:0] a);
    step(0, 1, 0, 0, a, 32'd0);
    step(0, 1, 1, 0, a, 32'd0);
  endtask

  task automatic rd_all();
    for (int unsigned i = 0; i < 4; i++) rd(12'(i * 4));
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 12'd0, 32'd0);
  endtask

  // Back-to-back access phases: samples a register every cycle.
  task automatic poll(logic [11:0] a, int unsigned n);
    step(0, 1, 0, 0, a, 32'd0);
    for (int unsigned i = 0; i < n; i++) step(0, 1, 1, 0, a, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    rd_t x;
    if (started) begin
      if (evq.size() == 0) begin
        checks++; errors++;
        $display("FAIL evq_underflow: got empty queue expected entry");
      end else begin
        chk("event_o", 32'(event_o), 32'(evq.pop_front()));
      end
      if (PSEL && PENABLE) begin
        chk("PREADY", 32'(PREADY), 32'd1);
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdq_underflow: got empty queue expected entry");
        end else begin
          x = rdq.pop_front();
          chk("PRDATA", PRDATA, x.data);
          chk("PSLVERR", 32'(PSLVERR), 32'(x.err));
        end
      end else if (!PSEL) begin
        chk("PRDATA_idle", PRDATA, 32'd0);
        chk("PSLVERR_idle", 32'(PSLVERR), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    logic [11:0] a;
    logic [31:0] d;
    rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 12'd0, 32'd0);
    started = 1;
    step(1, 0, 0, 0, 12'd0, 32'd0);
    rd_all();

    // Periodic mode.
    wr(12'h8, 32'd4);
    wr(12'h0, 32'h7);
    poll(12'h4, 10);
    rd(12'hC);
    wr(12'hC, 32'h1);
    wr(12'h0, 32'h0);

    // Prescaler and one-shot.
    wr(12'h4, 32'd0);
    wr(12'h8, 32'd2);
    wr(12'h0, 32'h301);
    poll(12'h4, 18);
    rd_all();
    wr(12'hC, 32'h1);

    // W1C collides with match.
    wr(12'h4, 32'd0);
    wr(12'h8, 32'd3);
    wr(12'h0, 32'h7);
    idle(2);
    wr(12'hC, 32'h1);
    idle(2);
    rd(12'hC);
    wr(12'h0, 32'h4);
    wr(12'hC, 32'h1);
    idle(2);

    // Address errors.
    rd(12'h010);
    wr(12'h006, 32'hDEAD);
    wr(12'h104, 32'h1234);
    rd_all();

    // Wrap then reset mid-run, with an access during reset.
    wr(12'h8, 32'd5);
    wr(12'h4, 32'hFFFF_FFFF);
    wr(12'h0, 32'h5);
    poll(12'h4, 4);
    rd(12'hC);
    step(1, 1, 1, 1, 12'h4, 32'h1234);
    step(1, 1, 1, 1, 12'h8, 32'h5678);
    rd_all();

    // Randomised traffic.
    for (int unsigned n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        step(1, $urandom_range(0, 1), 1, 1, 12'h4, $urandom);
      end else if (r < 45) begin
        a = 12'($urandom_range(0, 3) * 4);
        case (a[3:2])
          2'd0:    d = ($urandom & 32'hFFFF_F0F8) | 32'($urandom_range(0, 7))
                       | (32'($urandom_range(0, 3)) << 8);
          2'd1:    d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 12));
          2'd2:    d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
          default: d = $urandom;
        endcase
        wr(a, d);
      end else if (r < 70) begin
        rd(12'($urandom_range(0, 3) * 4));
      end else if (r < 78) begin
        a = 12'($urandom);
        if (!bad(a)) a[0] = 1'b1;
        if ($urandom_range(0, 1) == 1) wr(a, $urandom);
        else rd(a);
      end else begin
        idle($urandom_range(1, 4));
      end
    end
    rd_all();
    idle(2);

    chk("rdq_drained", 32'(rdq.size()), 32'd0);
    chk("evq_drained", 32'(evq.size()), 32'd0);
    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_timer_lite.md
APB_TIMER_LITE -- requirements
Module: apb_timer_lite

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, APB address width; the slave decodes a 4 KB window.
REQ-002 Parameter CNT_WIDTH, default 32, width of the counter and compare registers.
REQ-003 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 PADDR  input  APB_ADDR_WIDTH  APB address; only bits [3:2] and the all-zero upper bits are decoded.
REQ-006 PWDATA  input  32  APB write data.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PSEL  input  1  slave select from the axi2apb bridge.
REQ-009 PENABLE  input  1  APB access phase.
REQ-010 PRDATA  output  32  APB read data, valid in the access phase.
REQ-011 PREADY  output  1  transfer complete.
REQ-012 PSLVERR  output  1  transfer error.
REQ-013 event_o  output  1  level interrupt/event to the core irq lines.

Function
REQ-014 Register map (byte offsets):
- 0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [11:8] PRESC; other bits read 0.
- 0x4 COUNT: read/write.
- 0x8 CMP: read/write, CNT_WIDTH bits.
- 0xC STATUS: [0] MATCH, write-1-to-clear; writing 0 has no effect.
REQ-015 A transfer completes in a single access cycle (PSEL=1 and PENABLE=1). PREADY SHALL be tied to 1, giving zero wait states.
REQ-016 Register writes take effect on the clock edge that ends the access cycle. Nothing is written in the setup phase.
REQ-017 PRDATA SHALL be combinational from the registers during the access phase, and 0 when PSEL=0.
REQ-018 PSLVERR SHALL be 1 in the access phase when PADDR[APB_ADDR_WIDTH-1:4] != 0 or PADDR[1:0] != 0. In that case writes are ignored and PRDATA = 0.
REQ-019 Prescaler:
- A 4-bit counter psc runs while EN=1.
- A tick is generated when psc == PRESC; on the tick psc returns to 0, otherwise psc increments.
- PRESC=0 gives a tick every cycle.
- psc is held at 0 while EN=0.
REQ-020 On each tick, COUNT increments by 1, wrapping from all-ones to 0. A wrap alone does not set MATCH.
REQ-021 Match condition: a tick occurs and the pre-increment COUNT == CMP. On a match, MATCH is set to 1 on the same edge.
- If AUTO_RELOAD=1, COUNT is loaded with 0 instead of incrementing.
- If AUTO_RELOAD=0, COUNT increments and EN is cleared (one-shot).
REQ-022 The timer is a two-state FSM:
- IDLE (EN=0) -> RUN when software writes EN=1.
- RUN -> IDLE on a software write of EN=0, or on a one-shot match.
REQ-023 event_o = MATCH & IRQ_EN, registered-free (combinational from the flops). It stays high until MATCH is cleared or IRQ_EN=0.
REQ-024 Simultaneous events:
- A software COUNT write on a tick cycle: the written value wins and psc is reset to 0.
- A STATUS W1C on a match cycle: MATCH remains 1 (set wins).
- A CTRL write of EN=1 on a one-shot match cycle: EN remains 1.
REQ-025 Writing COUNT SHALL always reset psc to 0.
REQ-026 Writing CTRL with EN=0 SHALL not alter COUNT.

Reset
REQ-027 While rst_i=1 at a clock edge, the following SHALL be 0: CTRL, COUNT, STATUS and psc.
REQ-028 CMP SHALL reset to all-ones.
REQ-029 event_o SHALL be 0 in the cycle after reset.
REQ-030 PRDATA and PSLVERR SHALL be 0 when PSEL=0.
REQ-031 An APB access coincident with rst_i=1 SHALL have no effect on registers.
REQ-032 Assertion of rst_i mid-count SHALL abort the count immediately.

Verification
REQ-033 Periodic mode:
- Stimulus: CMP=4, CTRL=0x7 (PRESC=0).
- Response: COUNT sequence 0,1,2,3,4,0. MATCH and event_o rise on the edge where COUNT goes 4->0, i.e. 5 cycles after the CTRL write.
REQ-034 Prescaler and one-shot:
- Stimulus: CMP=2, CTRL=0x301 (PRESC=3, EN=1, AUTO_RELOAD=0).
- Response: COUNT increments every 4 cycles. MATCH sets 12 cycles after enable, COUNT=3, EN reads back 0, and COUNT then stays at 3.
REQ-035 W1C versus match collision:
- Stimulus: a STATUS write 0x1 in the same cycle as a match.
- Response: MATCH stays 1. A later STATUS write of 0x1 clears it and event_o falls the next cycle.
REQ-036 Address error:
- Stimulus: a read of 0x010, then a write of 0xDEAD to 0x006.
- Response: PSLVERR=1 and PRDATA=0 on both. No register changes. PREADY=1 throughout.
REQ-037 Wrap and reset:
- Stimulus: COUNT=0xFFFFFFFF, CMP=5, EN=1, PRESC=0. Then assert rst_i mid-run.
- Response: COUNT wraps to 0 with MATCH=0. After the reset edge, CTRL=0, COUNT=0, CMP=0xFFFFFFFF and event_o=0.
